// File: rtl/rca_adder_if.sv
// Operand/result bundle for rca_adder: the slave side is the adder, the master side feeds it.
interface rca_adder_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Ci;
    logic [N-1:0] S;
    logic         Co;
    logic         out_valid;

    modport master (
        output in_valid, A, B, Ci,
        input  S, Co, out_valid
    );

    modport slave (
        input  in_valid, A, B, Ci,
        output S, Co, out_valid
    );
endinterface

// File: rtl/rca_adder.sv
// Registered N-bit ripple-carry adder: {Co, S} = A + B + Ci, one cycle of latency.
// Each generate stage is one full-adder cell; the carry ripples from bit 0 to bit N-1.
module rca_adder #(
    parameter int N = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    rca_adder_if.slave bus
);
    logic [N:0]   carry;
    logic [N-1:0] sum;

    logic [N-1:0] s_d, s_q;
    logic         co_d, co_q;
    logic         out_valid_d, out_valid_q;

    assign carry[0] = bus.Ci;

    for (genvar i = 0; i < N; i++) begin : g_fa
        logic a_bit, b_bit, p_bit;

        assign a_bit      = bus.A[i];
        assign b_bit      = bus.B[i];
        assign p_bit      = a_bit ^ b_bit;
        assign sum[i]     = p_bit ^ carry[i];
        assign carry[i+1] = (a_bit & b_bit) | (carry[i] & p_bit);
    end

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path leaves a
        // variable unassigned and no latch is inferred; the default here is "hold".
        s_d         = s_q;
        co_d        = co_q;
        out_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            s_d  = sum;
            co_d = carry[N];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            co_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            co_q        <= co_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.S         = s_q;
    assign bus.Co        = co_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rca_adder.sv
// Self-checking bench for rca_adder: N=4 directed/exhaustive vectors and N=8 directed/random vectors.
module tb_rca_adder;
    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    rca_adder_if #(.N(4)) bus4 ();
    rca_adder_if #(.N(8)) bus8 ();

    rca_adder #(.N(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    rca_adder #(.N(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    // Drive the N=4 operands, then advance to just after the next rising edge.
    task automatic step4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic ci);
        bus4.in_valid = v;
        bus4.A        = a;
        bus4.B        = b;
        bus4.Ci       = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic ci);
        bus8.in_valid = v;
        bus8.A        = a;
        bus8.B        = b;
        bus8.Ci       = ci;
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic [4:0] exp_sum, input logic exp_v);
        check({tag, " sum"}, {27'd0, bus4.Co, bus4.S}, {27'd0, exp_sum});
        check({tag, " valid"}, {31'd0, bus4.out_valid}, {31'd0, exp_v});
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       ci;
        logic [4:0] exp;
    } vec4_t;

    vec4_t dir4[4];

    initial begin
        logic [4:0] model4;
        logic [8:0] model8;
        logic [7:0] ra, rb;
        logic       rci;

        n_checks = 0;
        n_fail   = 0;

        // Hand-computed directed vectors: {Co,S}
        dir4[0] = '{a: 4'h5, b: 4'h3, ci: 1'b1, exp: 5'h09};
        dir4[1] = '{a: 4'hF, b: 4'h0, ci: 1'b1, exp: 5'h10};
        dir4[2] = '{a: 4'hF, b: 4'hF, ci: 1'b1, exp: 5'h1F};
        dir4[3] = '{a: 4'h0, b: 4'h0, ci: 1'b0, exp: 5'h00};

        // Reset held with a valid all-ones operand on the bus.
        rst_n = 1'b0;
        bus4.in_valid = 1'b1; bus4.A = 4'hF; bus4.B = 4'h0; bus4.Ci = 1'b1;
        bus8.in_valid = 1'b0; bus8.A = 8'h00; bus8.B = 8'h00; bus8.Ci = 1'b0;
        #1;
        check4("reset_async", 5'h00, 1'b0);
        @(posedge clk); #1;
        check4("reset_hold1", 5'h00, 1'b0);
        step4(1'b1, 4'hF, 4'hF, 1'b1);
        check4("reset_hold2", 5'h00, 1'b0);
        check("reset_n8", {23'd0, bus8.out_valid, bus8.Co, bus8.S}, 32'd0);

        #3;
        rst_n = 1'b1;

        // Directed boundary vectors, back to back.
        for (int i = 0; i < 4; i++) begin
            step4(1'b1, dir4[i].a, dir4[i].b, dir4[i].ci);
            check4($sformatf("directed%0d", i), dir4[i].exp, 1'b1);
        end

        // Exhaustive sweep, no bubbles between vectors.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    model4 = 5'(a) + 5'(b) + 5'(c);
                    step4(1'b1, 4'(a), 4'(b), 1'(c));
                    check4($sformatf("sweep a=%0d b=%0d ci=%0d", a, b, c), model4, 1'b1);
                end
            end
        end

        // Hold: 7+8+1 = 16 -> S=0, Co=1, then persists with in_valid low.
        step4(1'b1, 4'h7, 4'h8, 1'b1);
        check4("hold_load", 5'h10, 1'b1);
        step4(1'b0, 4'h1, 4'h1, 1'b0);
        check4("hold_idle1", 5'h10, 1'b0);
        step4(1'b0, 4'h1, 4'h1, 1'b1);
        check4("hold_idle2", 5'h10, 1'b0);

        // Reset mid-stream: 3+4 lands, 9+2 is launched under reset and lost, 6+6+1 lands.
        step4(1'b1, 4'h3, 4'h4, 1'b0);
        check4("mid_before", 5'h07, 1'b1);
        bus4.A = 4'h9; bus4.B = 4'h2; bus4.Ci = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check4("mid_async_clear", 5'h00, 1'b0);
        @(posedge clk); #1;
        check4("mid_discard", 5'h00, 1'b0);
        #3;
        rst_n = 1'b1;
        #1;
        check4("mid_released", 5'h00, 1'b0);
        step4(1'b1, 4'h6, 4'h6, 1'b1);
        check4("mid_after", 5'h0D, 1'b1);
        step4(1'b0, 4'h0, 4'h0, 1'b0);
        check4("mid_idle", 5'h0D, 1'b0);

        // N=8: directed carry-out case, then random vectors against A+B+Ci.
        step8(1'b1, 8'hFF, 8'h01, 1'b0);
        check("n8_ff_01", {23'd0, bus8.out_valid, bus8.Co, bus8.S}, {23'd0, 1'b1, 9'h100});
        step8(1'b1, 8'hFF, 8'hFF, 1'b1);
        check("n8_max", {23'd0, bus8.out_valid, bus8.Co, bus8.S}, {23'd0, 1'b1, 9'h1FF});
        for (int i = 0; i < 1000; i++) begin
            ra     = 8'($urandom_range(0, 255));
            rb     = 8'($urandom_range(0, 255));
            rci    = 1'($urandom_range(0, 1));
            model8 = 9'(ra) + 9'(rb) + 9'(rci);
            step8(1'b1, ra, rb, rci);
            check($sformatf("n8_rand a=%0h b=%0h ci=%0d", ra, rb, rci),
                  {23'd0, bus8.out_valid, bus8.Co, bus8.S}, {23'd0, 1'b1, model8});
        end
        step8(1'b0, 8'h12, 8'h34, 1'b1);
        check("n8_hold", {23'd0, bus8.out_valid, bus8.Co, bus8.S}, {23'd0, 1'b0, model8});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rca_adder.md
Name: rca_adder

Overview:
- Registered N-bit ripple-carry adder: S/Co = A + B + Ci.
- Built as a chain of N one-bit full adders; the carry ripples from bit 0 to bit N-1.
- The sum and carry-out are captured in output registers, giving one cycle of latency.
- Arithmetic leaf block used by the sign-magnitude adder datapath and by any unsigned add path.

Parameters:
- N, default 4, operand and sum width in bits; legal range N >= 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies A/B/Ci this cycle.
- A  input  N  unsigned operand A.
- B  input  N  unsigned operand B.
- Ci  input  1  carry-in to bit 0.
- S  output  N  registered sum bits.
- Co  output  1  registered carry-out from bit N-1.
- out_valid  output  1  S/Co hold a result launched on the previous cycle.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Full-adder cell, per bit i, with c0 = Ci:
  - s_i = A[i] ^ B[i] ^ c_i.
  - c_(i+1) = (A[i] & B[i]) | (c_i & (A[i] ^ B[i])).
  - Co_next = c_N.
- Structure: explicit N-stage chain (generate loop of full-adder instances). Combinational path A/B/Ci -> c_N is N cells deep. No lookahead logic.
- Width rule: {Co, S} = A + B + Ci exactly, as an (N+1)-bit unsigned result. No truncation or saturation.
- Registers, on posedge clk:
  - When in_valid=1, S and Co load the ripple result.
  - When in_valid=0, S and Co hold their previous values.
  - out_valid loads in_valid every cycle.
- Latency: exactly 1 cycle from inputs to S/Co. Throughput: one add per cycle.
- There is no backpressure.
- Reset:
  - rst_n low forces S=0, Co=0 and out_valid=0 immediately, independent of clk.
  - Reset asserted mid-operation discards any in-flight result.
  - Reset release is synchronised by the integrating level, not inside this block.
  - The first in_valid sampled after release produces out_valid=1 on the next cycle.
- Boundary cases:
  - All-ones + 0 with Ci=1: the carry propagates through every stage. Result S=0, Co=1.
  - A=B=all-ones with Ci=1: S=all-ones, Co=1. This is the maximum result 2^(N+1)-1.
  - Ci=0, A=B=0: S=0, Co=0.
- Back-to-back valid inputs produce back-to-back outputs with no bubbles.
- X/Z inputs are not handled specially.

Test Plan:
- Reset: drive rst_n=0 with in_valid=1 and A=4'hF -> S=0, Co=0, out_valid=0 asynchronously. Values stay at 0 while reset is held.
- Exhaustive sweep, N=4: all A, B in 0..15 with Ci in {0,1}, in_valid=1. Expect {Co,S} = A+B+Ci one cycle later and out_valid=1 every cycle. Example: A=5, B=3, Ci=1 -> S=4'h9, Co=0.
- Full carry propagation: A=4'hF, B=4'h0, Ci=1 -> S=4'h0, Co=1. Then A=4'hF, B=4'hF, Ci=1 -> S=4'hF, Co=1.
- Hold behaviour: load A=7, B=8, Ci=1 (expect S=0, Co=1). Then set in_valid=0 and change A=1, B=1 -> S=0, Co=1 persist and out_valid=0.
- Reset mid-stream: pulse rst_n low between two valid adds. Expect outputs to clear immediately; the add launched in the reset cycle never appears; the next add after release appears with 1-cycle latency.
- Parameter check: N=8 with A=8'hFF, B=8'h01, Ci=0 -> S=8'h00, Co=1. Plus a random 1000-vector comparison against A+B+Ci.
